io_input_conditioner: RTL and testbench

- Upstream stage of the control module's `input_io` port.
- Takes asynchronous raw pins and passes each one through a 2-flop synchroniser and a per-channel debounce filter.
- The clean `filtered_io` bus feeds the controller.
- A sticky per-channel change mask with a valid/ack handshake tells the control logic which inputs toggled since it last acknowledged.

---
 rtl/io_input_conditioner.sv | 72 +++++++
 tb/tb_io_input_conditioner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_conditioner.sv
// Input conditioner: 2-flop synchroniser and per-channel debounce filter for raw pins,
// with a sticky change mask the controller reads and acknowledges.
module io_input_conditioner #(
  parameter int INPUTS         = 32,
  parameter int DEBOUNCE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INPUTS-1:0]         raw_io,
  input  logic                      enable,
  input  logic [DEBOUNCE_WIDTH-1:0] debounce_cycles,
  output logic [INPUTS-1:0]         filtered_io,
  output logic [INPUTS-1:0]         change_mask,
  output logic                      change_valid,
  input  logic                      change_ack
);

  logic [INPUTS-1:0]         s1_q, s1_d;
  logic [INPUTS-1:0]         s2_q, s2_d;
  logic [INPUTS-1:0]         filt_q, filt_d;
  logic [INPUTS-1:0]         mask_q, mask_d;
  logic [INPUTS-1:0]         commit_set;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q [INPUTS];
  logic [DEBOUNCE_WIDTH-1:0] cnt_d [INPUTS];

  always_comb begin
    s1_d       = raw_io;
    s2_d       = s1_q;
    filt_d     = filt_q;
    commit_set = '0;
    for (int i = 0; i < INPUTS; i++) begin
      cnt_d[i] = '0;
      // Commit uses >= so a lowered threshold takes effect on the very next edge.
      if (enable && (s2_q[i] != filt_q[i])) begin
        if (cnt_q[i] >= debounce_cycles) begin
          filt_d[i]     = s2_q[i];
          commit_set[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // Handshake: change_valid is high while any mask bit is set; change_ack clears the
    // bits held this cycle, while commits landing on the same edge are kept.
    mask_d = (change_ack ? '0 : mask_q) | commit_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      filt_q <= '0;
      mask_q <= '0;
      for (int i = 0; i < INPUTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      mask_q <= mask_d;
      for (int i = 0; i < INPUTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign filtered_io  = filt_q;
  assign change_mask  = mask_q;
  assign change_valid = |mask_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed vector table, hand-written corner sequences,
// and a randomized run against a run-length reference model.
module tb_io_input_conditioner;

  logic        clk;
  logic        rst;
  logic [31:0] raw_io;
  logic        enable;
  logic [15:0] debounce_cycles;
  logic [31:0] filtered_io;
  logic [31:0] change_mask;
  logic        change_valid;
  logic        change_ack;

  int errors = 0;
  int checks = 0;

  io_input_conditioner #(
    .INPUTS        (32),
    .DEBOUNCE_WIDTH(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .raw_io         (raw_io),
    .enable         (enable),
    .debounce_cycles(debounce_cycles),
    .filtered_io    (filtered_io),
    .change_mask    (change_mask),
    .change_valid   (change_valid),
    .change_ack     (change_ack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: a pin sample reaches the filter two edges later; a channel commits
  // once it has differed from the filtered value for more than N consecutive enabled edges
  logic [31:0] m_pipe [$];
  logic [31:0] m_filt;
  logic [31:0] m_mask;
  logic [31:0] m_s2;
  logic [31:0] m_set;
  int          m_run [32];
  bit          track = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_mask_q [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pipe.delete();
      m_pipe.push_back(32'h0);
      m_pipe.push_back(32'h0);
      m_filt = '0;
      m_mask = '0;
      for (int i = 0; i < 32; i++) m_run[i] = 0;
    end else begin
      m_s2  = m_pipe[0];
      m_set = '0;
      for (int i = 0; i < 32; i++) begin
        if (!enable || (m_s2[i] == m_filt[i])) begin
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] > int'(debounce_cycles)) begin
            m_filt[i] = m_s2[i];
            m_set[i]  = 1'b1;
            m_run[i]  = 0;
          end
        end
      end
      m_mask = (change_ack ? 32'h0 : m_mask) | m_set;
      void'(m_pipe.pop_front());
      m_pipe.push_back(raw_io);
      if (track) begin
        exp_q.push_back(m_filt);
        exp_mask_q.push_back(m_mask);
      end
    end
  end

  // directed vector table
  typedef struct {
    logic [31:0] raw;
    logic        en;
    logic [15:0] n;
    logic        ack;
    logic [31:0] exp_filt;
    logic [31:0] exp_mask;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input logic [31:0] raw, input logic en, input logic [15:0] n,
                         input logic ack, input logic [31:0] ef, input logic [31:0] em,
                         input logic ev);
    vec_t v;
    v.raw = raw; v.en = en; v.n = n; v.ack = ack;
    v.exp_filt = ef; v.exp_mask = em; v.exp_valid = ev;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; raw_io = '0; enable = 1'b1; debounce_cycles = '0; change_ack = 1'b0;

    // N=0 single bit, then ack; ack with empty mask
    add_vec(32'h1, 1, 0, 0, 32'h0, 32'h0, 0);
    add_vec(32'h1, 1, 0, 0, 32'h0, 32'h0, 0);
    add_vec(32'h1, 1, 0, 0, 32'h1, 32'h1, 1);
    add_vec(32'h1, 1, 0, 1, 32'h1, 32'h0, 0);
    add_vec(32'h1, 1, 0, 1, 32'h1, 32'h0, 0);
    // N=4: bit 3 high for 4 cycles is rejected
    for (int k = 0; k < 4; k++) add_vec(32'h9, 1, 4, 0, 32'h1, 32'h0, 0);
    for (int k = 0; k < 3; k++) add_vec(32'h1, 1, 4, 0, 32'h1, 32'h0, 0);
    // held 10 cycles: commits on the 7th edge (E6)
    for (int k = 0; k < 6; k++) add_vec(32'h9, 1, 4, 0, 32'h1, 32'h0, 0);
    for (int k = 0; k < 4; k++) add_vec(32'h9, 1, 4, 0, 32'h9, 32'h8, 1);
    add_vec(32'h9, 1, 4, 1, 32'h9, 32'h0, 0);

    tick();
    tick();
    chk("reset_filtered", filtered_io, 32'h0);
    chk("reset_mask", change_mask, 32'h0);
    chk("reset_valid", {31'h0, change_valid}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      raw_io = vecs[i].raw; enable = vecs[i].en;
      debounce_cycles = vecs[i].n; change_ack = vecs[i].ack;
      tick();
      chk($sformatf("vec%0d_filtered", i), filtered_io, vecs[i].exp_filt);
      chk($sformatf("vec%0d_mask", i), change_mask, vecs[i].exp_mask);
      chk($sformatf("vec%0d_valid", i), {31'h0, change_valid}, {31'h0, vecs[i].exp_valid});
    end
    change_ack = 1'b0;

    // commit on bit 0 coincides with ack clearing bit 5
    do_reset();
    debounce_cycles = 16'd3; raw_io = 32'h20;
    for (int k = 0; k < 5; k++) tick();
    chk("n3_before_commit", filtered_io, 32'h0);
    tick();
    chk("n3_bit5_filtered", filtered_io, 32'h20);
    chk("n3_bit5_mask", change_mask, 32'h20);
    raw_io = 32'h21;
    for (int k = 0; k < 5; k++) tick();
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
    chk("ack_set_mask", change_mask, 32'h1);
    chk("ack_set_valid", {31'h0, change_valid}, 32'h1);
    chk("ack_set_filtered", filtered_io, 32'h21);

    // lowering the threshold mid-count commits on the next edge
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
    debounce_cycles = 16'd10; raw_io = 32'hA1;
    for (int k = 0; k < 8; k++) tick();
    chk("n10_cnt6_hold", filtered_io, 32'h21);
    debounce_cycles = 16'd2;
    tick();
    chk("lower_n_filtered", filtered_io, 32'hA1);
    chk("lower_n_mask", change_mask, 32'h80);

    // enable=0 freezes filtering; restart with N=0
    do_reset();
    enable = 1'b0; raw_io = 32'hFFFF_FFFF; debounce_cycles = 16'd0;
    for (int k = 0; k < 20; k++) tick();
    chk("disabled_filtered", filtered_io, 32'h0);
    chk("disabled_mask", change_mask, 32'h0);
    enable = 1'b1;
    tick();
    chk("reenable_filtered", filtered_io, 32'hFFFF_FFFF);
    chk("reenable_mask", change_mask, 32'hFFFF_FFFF);
    chk("reenable_valid", {31'h0, change_valid}, 32'h1);

    // asynchronous reset between edges, mid-count
    do_reset();
    debounce_cycles = 16'd1; raw_io = 32'hA5;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_async_filtered", filtered_io, 32'hA5);
    debounce_cycles = 16'd5; raw_io = 32'h5A;
    for (int k = 0; k < 4; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_filtered", filtered_io, 32'h0);
    chk("async_rst_mask", change_mask, 32'h0);
    chk("async_rst_valid", {31'h0, change_valid}, 32'h0);
    #1;
    rst = 1'b0;
    raw_io = 32'hA5; debounce_cycles = 16'd1;
    for (int k = 0; k < 3; k++) tick();
    chk("post_rst_e2", filtered_io, 32'h0);
    tick();
    chk("post_rst_e3_filtered", filtered_io, 32'hA5);
    chk("post_rst_e3_mask", change_mask, 32'hA5);

    // randomized run against the reference model
    do_reset();
    exp_q.delete();
    exp_mask_q.delete();
    track = 1'b1;
    raw_io = $urandom;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      raw_io = raw_io ^ ($urandom & $urandom & $urandom);
      if ((cyc % 64) == 0) debounce_cycles = 16'($urandom_range(0, 5));
      enable     = ($urandom_range(0, 15) != 0);
      change_ack = ($urandom_range(0, 3) == 0);
      tick();
      if (exp_q.size() == 0 || exp_mask_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rand_queue_empty: got 0 entries expected 1 at cycle %0d", cyc);
      end else begin
        logic [31:0] ef;
        logic [31:0] em;
        ef = exp_q.pop_front();
        em = exp_mask_q.pop_front();
        chk($sformatf("rand%0d_filtered", cyc), filtered_io, ef);
        chk($sformatf("rand%0d_mask", cyc), change_mask, em);
        chk($sformatf("rand%0d_valid", cyc), {31'h0, change_valid}, {31'h0, |em});
      end
    end
    track = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
